// File: rtl/tetris_pkg.sv
// Shared piece definitions for the Tetris randomizer blocks: code width, empty-slot
// marker, piece enum and the Galois feedback masks used by the random source.
package tetris_pkg;

  localparam int NUM_PIECES_DEFAULT = 7;
  localparam int PIECE_W_DEFAULT    = 3;

  typedef logic [PIECE_W_DEFAULT-1:0] piece_t;

  localparam piece_t PIECE_NONE = '1;

  typedef enum logic [PIECE_W_DEFAULT-1:0] {
    PIECE_I = 3'd0,
    PIECE_O = 3'd1,
    PIECE_T = 3'd2,
    PIECE_S = 3'd3,
    PIECE_Z = 3'd4,
    PIECE_J = 3'd5,
    PIECE_L = 3'd6
  } piece_code_e;

  // Right-shifting Galois mask: bit k set means polynomial term x^(k+1).
  function automatic logic [31:0] galois_taps(input int width);
    case (width)
      4:       return 32'h0000_000C;
      8:       return 32'h0000_00B8;
      24:      return 32'h00E1_0000;
      32:      return 32'h8020_0003;
      default: return 32'h0000_B400;
    endcase
  endfunction

endpackage

// File: rtl/piece_bag_queue_lfsr.sv
// Maximal-length Galois LFSR that advances every cycle, with an optional
// synchronous load (a zero load value is replaced by 1 to avoid lock-up).
module lfsr
  import tetris_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] SEED  = 16'hACE1
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] TAPS = WIDTH'(galois_taps(WIDTH));
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] state_q, state_d;

  always_comb begin
    state_d = {1'b0, state_q[WIDTH-1:1]} ^ (state_q[0] ? TAPS : '0);
    if (load) begin
      state_d = (load_val == '0) ? ONE : load_val;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign q = state_q;

endmodule

// File: rtl/piece_bag_queue.sv
// 7-bag piece randomizer feeding a FIFO preview queue. Define BAG_SEED_LOAD_EN
// to add the seed_load/seed ports for run-time reseeding of the random source.
module piece_bag_queue
  import tetris_pkg::*;
#(
  parameter int                NUM_PIECES = NUM_PIECES_DEFAULT,
  parameter int                PIECE_W    = PIECE_W_DEFAULT,
  parameter int                DEPTH      = 5,
  parameter int                LFSR_W     = 16,
  parameter logic [LFSR_W-1:0] SEED       = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         nreset,
  input  logic                         flush,
  input  logic                         pop,
`ifdef BAG_SEED_LOAD_EN
  input  logic                         seed_load,
  input  logic [LFSR_W-1:0]            seed,
`endif
  output logic [PIECE_W-1:0]           head,
  output logic                         head_valid,
  output logic [DEPTH*PIECE_W-1:0]     preview,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         bag_wrap
);

  localparam int               CW        = $clog2(DEPTH+1);
  localparam logic [CW-1:0]    DEPTH_C   = CW'(DEPTH);
  localparam logic [PIECE_W-1:0] NONE_CODE = '1;

  logic [PIECE_W-1:0]    queue_q [DEPTH];
  logic [PIECE_W-1:0]    queue_d [DEPTH];
  logic [CW-1:0]         count_q, count_d;
  logic [NUM_PIECES-1:0] flags_q, flags_d;
  logic                  wrap_q, wrap_d;

  logic [LFSR_W-1:0]     lfsr_q;
  logic                  lfsr_load;
  logic [LFSR_W-1:0]     lfsr_load_val;
  logic                  lfsr_unused;

  logic [PIECE_W-1:0]    cand;
  logic [CW-1:0]         wr_idx;
  logic                  pop_acc, push, cand_ok;

`ifdef BAG_SEED_LOAD_EN
  assign lfsr_load     = seed_load;
  assign lfsr_load_val = seed;
`else
  assign lfsr_load     = 1'b0;
  assign lfsr_load_val = '0;
`endif

  lfsr #(
    .WIDTH (LFSR_W),
    .SEED  (SEED)
  ) u_lfsr (
    .clk      (clk),
    .nreset   (nreset),
    .load     (lfsr_load),
    .load_val (lfsr_load_val),
    .q        (lfsr_q)
  );

  assign cand        = lfsr_q[PIECE_W-1:0];
  assign lfsr_unused = ^lfsr_q[LFSR_W-1:PIECE_W];

  // Pop shifts the queue down first, so a same-cycle push lands one slot lower.
  always_comb begin
    pop_acc = pop && (count_q != '0) && !flush;
    cand_ok = (int'(cand) < NUM_PIECES) && !flags_q[cand];
    push    = !flush && cand_ok && ((count_q != DEPTH_C) || pop_acc);
    wr_idx  = count_q - CW'(pop_acc);

    for (int i = 0; i < DEPTH; i++) queue_d[i] = queue_q[i];
    if (pop_acc) begin
      for (int i = 0; i < DEPTH-1; i++) queue_d[i] = queue_q[i+1];
      queue_d[DEPTH-1] = NONE_CODE;
    end
    if (push) queue_d[wr_idx] = cand;

    count_d = count_q - CW'(pop_acc) + CW'(push);

    flags_d = flags_q;
    wrap_d  = 1'b0;
    if (push) begin
      flags_d[cand] = 1'b1;
      if (&flags_d) begin
        flags_d = '0;
        wrap_d  = 1'b1;
      end
    end

    if (flush) begin
      for (int i = 0; i < DEPTH; i++) queue_d[i] = NONE_CODE;
      count_d = '0;
      flags_d = '0;
      wrap_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < DEPTH; i++) queue_q[i] <= NONE_CODE;
      count_q <= '0;
      flags_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      queue_q <= queue_d;
      count_q <= count_d;
      flags_q <= flags_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    preview = '0;
    for (int i = 0; i < DEPTH; i++) preview[i*PIECE_W +: PIECE_W] = queue_q[i];
  end

  assign head       = queue_q[0];
  assign head_valid = (count_q != '0);
  assign count      = count_q;
  assign bag_wrap   = wrap_q;

endmodule

// File: tb/tb_piece_bag_queue.sv
// Self-checking bench for piece_bag_queue: queue/bag reference model with random
// stimulus, plus literal expectations for the first pushes from the reset seed.
module tb_piece_bag_queue;

  logic        clk    = 1'b0;
  logic        nreset = 1'b0;
  logic        flush  = 1'b0;
  logic        pop    = 1'b0;
`ifdef BAG_SEED_LOAD_EN
  logic        seed_load = 1'b0;
  logic [15:0] seed      = 16'h0;
`endif
  logic [2:0]  head;
  logic        head_valid;
  logic [14:0] preview;
  logic [2:0]  count;
  logic        bag_wrap;

  int nCompared   = 0;
  int nMismatched = 0;
  int wrapSeen    = 0;

  int          mq[$];
  bit [6:0]    mFlags;
  bit          mWrap;
  logic [15:0] mLfsr;
  int          popped[$];
  int          runA[$];

  always #5 clk = ~clk;

  piece_bag_queue #(
    .NUM_PIECES (7),
    .PIECE_W    (3),
    .DEPTH      (5),
    .LFSR_W     (16),
    .SEED       (16'hACE1)
  ) dut (
    .clk        (clk),
    .nreset     (nreset),
    .flush      (flush),
    .pop        (pop),
`ifdef BAG_SEED_LOAD_EN
    .seed_load  (seed_load),
    .seed       (seed),
`endif
    .head       (head),
    .head_valid (head_valid),
    .preview    (preview),
    .count      (count),
    .bag_wrap   (bag_wrap)
  );

  task automatic cmp(input string name, input int act, input int exp);
    nCompared++;
    if (act != exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    mFlags = '0;
    mWrap  = 1'b0;
    mLfsr  = 16'hACE1;
  endtask

  // One clock edge of the bag rules applied to the model state.
  task automatic modelStep(input bit f, input bit p, input bit sl, input logic [15:0] sv);
    int          cand;
    bit          popOk, ok;
    logic [15:0] nl;
    cand = int'(mLfsr[2:0]);
    nl   = (mLfsr >> 1) ^ (mLfsr[0] ? 16'hB400 : 16'h0000);
    if (sl) nl = (sv == 16'h0) ? 16'h0001 : sv;
    if (f) begin
      mq.delete();
      mFlags = '0;
      mWrap  = 1'b0;
    end else begin
      popOk = p && (mq.size() > 0);
      ok    = (cand < 7) && !mFlags[cand] && ((mq.size() < 5) || popOk);
      if (popOk) void'(mq.pop_front());
      mWrap = 1'b0;
      if (ok) begin
        mq.push_back(cand);
        mFlags[cand] = 1'b1;
        if (mFlags == 7'h7F) begin
          mFlags = '0;
          mWrap  = 1'b1;
        end
      end
    end
    mLfsr = nl;
  endtask

  task automatic checkOutput(input string tag);
    logic [14:0] ep;
    ep = '1;
    for (int i = 0; i < mq.size(); i++) ep[i*3 +: 3] = 3'(mq[i]);
    cmp({tag, ".head"},       int'(head),       mq.size() > 0 ? mq[0] : 7);
    cmp({tag, ".head_valid"}, int'(head_valid), int'(mq.size() > 0));
    cmp({tag, ".count"},      int'(count),      mq.size());
    cmp({tag, ".preview"},    int'(preview),    int'(ep));
    cmp({tag, ".bag_wrap"},   int'(bag_wrap),   int'(mWrap));
  endtask

  // Called at a falling edge: drive, advance the model, then check at the next falling edge.
  task automatic applyStimulus(input bit f, input bit p, input bit sl = 1'b0,
                               input logic [15:0] sv = 16'h0);
    flush = f;
    pop   = p;
`ifdef BAG_SEED_LOAD_EN
    seed_load = sl;
    seed      = sv;
`endif
    if (p && !f && head_valid) popped.push_back(int'(head));
    modelStep(f, p, sl, sv);
    @(negedge clk);
    checkOutput("cycle");
    if (bag_wrap) wrapSeen++;
  endtask

  task automatic checkPerm(input string name, input int start);
    int mask;
    mask = 0;
    for (int i = start; i < start + 7 && i < popped.size(); i++)
      if (popped[i] >= 0 && popped[i] < 7) mask |= (1 << popped[i]);
    cmp(name, mask, 32'h7F);
  endtask

  initial begin
    modelReset();
    repeat (2) @(negedge clk);
    checkOutput("reset");

    // Seed ACE1 yields candidates 1,0,0,4,6,7,3 on the first seven edges.
    nreset   = 1'b1;
    wrapSeen = 0;
    applyStimulus(1'b0, 1'b0);
    cmp("pinFirstHead", int'(head), 1);
    repeat (6) applyStimulus(1'b0, 1'b0);
    cmp("pinPreview", int'(preview), 32'h3D01);
    cmp("pinCount5", int'(count), 5);
    repeat (3) applyStimulus(1'b0, 1'b0);
    cmp("holdCount5", int'(count), 5);

    popped.delete();
    for (int c = 0; c < 200 && popped.size() < 14; c++) applyStimulus(1'b0, 1'b1);
    cmp("popsDone14", popped.size(), 14);
    checkPerm("bag1Perm", 0);
    checkPerm("bag2Perm", 7);
    cmp("wrapTwice", wrapSeen, 2);

    repeat (30) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1);
    cmp("flushCount", int'(count), 0);
    cmp("flushHead", int'(head), 7);
    cmp("flushValid", int'(head_valid), 0);
    cmp("flushWrap", int'(bag_wrap), 0);
    popped.delete();
    for (int c = 0; c < 200 && popped.size() < 7; c++) applyStimulus(1'b0, 1'b1);
    cmp("popsAfterFlush", popped.size(), 7);
    checkPerm("bagAfterFlushPerm", 0);

    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 63) == 0) begin
        #2 nreset = 1'b0;
        #1 modelReset();
        checkOutput("asyncReset");
        @(negedge clk);
        checkOutput("resetHeld");
        nreset = 1'b1;
      end else begin
`ifdef BAG_SEED_LOAD_EN
        applyStimulus($urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 31) == 0, 16'($urandom()));
`else
        applyStimulus($urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)));
`endif
      end
    end

`ifdef BAG_SEED_LOAD_EN
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000);
    cmp("seedZero", int'(dut.u_lfsr.q), 1);
    for (int run = 0; run < 2; run++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 16'h5EED);
      popped.delete();
      for (int c = 0; c < 300 && popped.size() < 10; c++) applyStimulus(1'b0, 1'b1);
      cmp("seedRunPops", popped.size(), 10);
      if (run == 0) runA = popped;
      else for (int i = 0; i < 10 && i < popped.size() && i < runA.size(); i++)
        cmp("seedRepeat", popped[i], runA[i]);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/piece_bag_queue.md
PIECE_BAG_QUEUE -- requirements
Module: piece_bag_queue

Interface
REQ-001 SHALL have parameter NUM_PIECES, default 7: distinct piece codes per bag (0..NUM_PIECES-1).
REQ-002 SHALL have parameter PIECE_W, default 3: piece code width; SHALL satisfy 2**PIECE_W > NUM_PIECES.
REQ-003 SHALL have parameter DEPTH, default 5: preview queue depth.
REQ-004 SHALL have parameter LFSR_W, default 16: random source width; parameter SEED, default 16'hACE1: reset seed.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 nreset  input  1  asynchronous, active-low reset.
REQ-007 flush  input  1  synchronous new-game clear of queue and bag.
REQ-008 pop  input  1  consumer takes head piece this cycle.
REQ-009 head  output  PIECE_W  piece at queue head; all-ones (PIECE_NONE) when empty.
REQ-010 head_valid  output  1  queue non-empty.
REQ-011 preview  output  DEPTH*PIECE_W  queue contents, entry 0 (head) in LSBs; empty slots all-ones.
REQ-012 count  output  $clog2(DEPTH+1)  occupied entries.
REQ-013 bag_wrap  output  1  one-cycle pulse when the last piece of a bag is pushed.
REQ-014 seed_load  input  1; seed  input  LFSR_W -- present only with BAG_SEED_LOAD_EN.

Function
REQ-015 LFSR SHALL advance every cycle (maximal-length Galois taps for LFSR_W); candidate = lfsr[PIECE_W-1:0].
REQ-016 Candidate SHALL be accepted iff candidate < NUM_PIECES, its bag flag is clear, and (count < DEPTH or pop is accepted this cycle).
REQ-017 On accept: candidate pushed at queue tail, flag set; at most one push per cycle.
REQ-018 When the accepted piece sets the last clear flag, all flags SHALL clear in that same edge and bag_wrap SHALL pulse; next bag starts next cycle.
REQ-019 pop SHALL be accepted only when head_valid; pop on empty queue is ignored, no state change.
REQ-020 Simultaneous accepted pop and push SHALL keep count unchanged; allowed when full.
REQ-021 Popped data SHALL be visible on head combinationally before the edge; new head appears the cycle after pop.
REQ-022 Queue order SHALL be FIFO; every NUM_PIECES consecutive pushes from a bag boundary form a permutation of 0..NUM_PIECES-1.
REQ-023 flush SHALL, next edge: count=0, all flags clear, bag_wrap=0, no push that cycle, pop ignored; LFSR keeps advancing (not reseeded).
REQ-024 Earliest first push: first rising edge after nreset deasserts, if candidate valid.

Reset
REQ-025 nreset low SHALL asynchronously set lfsr=SEED, count=0, flags=0, bag_wrap=0, all queue entries PIECE_NONE.
REQ-026 Reset asserted mid-operation SHALL discard queue and bag without completing any pending push/pop.
REQ-027 Outputs during reset: head=PIECE_NONE, head_valid=0, preview all-ones, count=0.

Configuration
REQ-028 Macro BAG_SEED_LOAD_EN defined: seed_load/seed ports exist; seed_load high loads lfsr=seed (zero replaced by 1) next edge, takes priority over advancing; combined with flush both apply.
REQ-029 Macro undefined: ports absent, LFSR only reseeded by nreset.

Structure
REQ-030 Shared package tetris_pkg SHALL hold piece_t typedef, NUM_PIECES default, PIECE_NONE constant, piece code enum.
REQ-031 One sub-module lfsr (parameters WIDTH, SEED; ports clk, nreset, load, load_val, q) SHALL be instantiated.

Verification
REQ-032 Reset release, pop=0 -> count reaches 5, 5 distinct codes in 0..6, count holds at 5, no further pushes.
REQ-033 Fill then pop each cycle for 14 pops -> pops 1-7 and 8-14 each a permutation of 0..6; bag_wrap pulses exactly twice.
REQ-034 pop=1 with count=0 after flush -> count stays 0, head=3'b111, head_valid=0.
REQ-035 count=5, pop and valid candidate same cycle -> count stays 5, old head removed, candidate at entry 4.
REQ-036 flush with count=5 and 3 flags set -> next cycle count=0, flags 0; subsequent 7 pushes are a permutation of 0..6.
REQ-037 With BAG_SEED_LOAD_EN: seed_load=1, seed=16'h0000 -> lfsr=16'h0001 next cycle; two runs with identical seed yield identical piece sequences.
